// File: rtl/stack_tos_pkg.sv
// Shared constants and width helpers for the TOS/NOS data stack.
// Imported by stack_tos and stack_ram.
package stack_tos_pkg;

  // Full-stack policy selectors for the OVFMODE parameter
  localparam int OVF_SAT  = 0;
  localparam int OVF_WRAP = 1;

  // Width of a counter able to hold 0..depth inclusive
  function automatic int nlevel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of an index into a depth-entry storage array
  function automatic int nptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/stack_ram.sv
// DEPTH x NBDATA stack storage: one synchronous write port and two
// asynchronous read ports (top and top-1), suited to distributed RAM.
module stack_ram
  import stack_tos_pkg::*;
#(
  parameter int  NBDATA = 32,
  parameter int  DEPTH  = 8,
  localparam int NPTR   = nptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [NPTR-1:0]   waddr_i,
  input  logic [NBDATA-1:0] wdata_i,
  input  logic [NPTR-1:0]   raddr_top_i,
  input  logic [NPTR-1:0]   raddr_nos_i,
  output logic [NBDATA-1:0] rdata_top_o,
  output logic [NBDATA-1:0] rdata_nos_o
);

  logic [NBDATA-1:0] mem_q [DEPTH];

  // Contents are never reset; the owner masks reads with its level counter
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_top_o = mem_q[raddr_top_i];
  assign rdata_nos_o = mem_q[raddr_nos_i];

endmodule

// File: rtl/stack_tos.sv
// Parametrised processor data stack exposing TOS/NOS with zero read latency,
// occupancy level, sticky overflow/underflow and a saturate/wrap full policy.
module stack_tos
  import stack_tos_pkg::*;
#(
  parameter int  NBDATA  = 32,
  parameter int  DEPTH   = 8,
  parameter int  OVFMODE = OVF_SAT,
  localparam int NLEVEL  = nlevel_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic              clr_err,
  input  logic [NBDATA-1:0] din,
  output logic [NBDATA-1:0] tos,
  output logic [NBDATA-1:0] nos,
  output logic [NLEVEL-1:0] level,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              udf
);

  localparam int NPTR = nptr_w(DEPTH);
  localparam logic [NPTR-1:0]   PTR_LAST  = NPTR'(DEPTH - 1);
  localparam logic [NLEVEL-1:0] LEVEL_MAX = NLEVEL'(DEPTH);
  localparam logic [NLEVEL-1:0] LEVEL_TWO = NLEVEL'(2);

  // base_q: slot of the oldest entry; wp_q: first free slot above the top.
  // Both advance modulo DEPTH so DEPTH need not be a power of two.
  logic [NPTR-1:0]   base_q, base_d;
  logic [NPTR-1:0]   wp_q, wp_d;
  logic [NLEVEL-1:0] level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              ram_we;
  logic [NPTR-1:0]   ram_waddr;
  logic [NPTR-1:0]   top_idx;
  logic [NPTR-1:0]   nos_idx;
  logic [NBDATA-1:0] ram_top;
  logic [NBDATA-1:0] ram_nos;
  logic              is_empty;
  logic              is_full;

  function automatic logic [NPTR-1:0] ptr_inc(input logic [NPTR-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [NPTR-1:0] ptr_dec(input logic [NPTR-1:0] p);
    return (p == '0) ? PTR_LAST : p - 1'b1;
  endfunction

  assign top_idx  = ptr_dec(wp_q);
  assign nos_idx  = ptr_dec(top_idx);
  assign is_empty = (level_q == '0);
  assign is_full  = (level_q == LEVEL_MAX);

  always_comb begin
    base_d    = base_q;
    wp_d      = wp_q;
    level_d   = level_q;
    ovf_d     = ovf_q & ~clr_err;
    udf_d     = udf_q & ~clr_err;
    ram_we    = 1'b0;
    ram_waddr = wp_q;

    if (flush) begin
      level_d = '0;
      wp_d    = base_q;
    end else if (push && pop && !is_empty) begin
      // Replace: overwrite the top slot in place, never an overflow
      ram_we    = 1'b1;
      ram_waddr = top_idx;
    end else if (push) begin
      if (!is_full) begin
        ram_we    = 1'b1;
        wp_d      = ptr_inc(wp_q);
        level_d   = level_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
        if (OVFMODE == OVF_WRAP) begin
          // When full the free slot coincides with base: overwrite the oldest
          ram_we = 1'b1;
          wp_d   = ptr_inc(wp_q);
          base_d = ptr_inc(base_q);
        end
      end
    end else if (pop) begin
      if (!is_empty) begin
        wp_d    = top_idx;
        level_d = level_q - 1'b1;
      end else begin
        udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q  <= '0;
      wp_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      base_q  <= base_d;
      wp_q    <= wp_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  stack_ram #(
    .NBDATA (NBDATA),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk         (clk),
    .we_i        (ram_we),
    .waddr_i     (ram_waddr),
    .wdata_i     (din),
    .raddr_top_i (top_idx),
    .raddr_nos_i (nos_idx),
    .rdata_top_o (ram_top),
    .rdata_nos_o (ram_nos)
  );

  // Storage is not cleared by reset or flush, so gate reads by occupancy
  assign tos   = is_empty ? '0 : ram_top;
  assign nos   = (level_q >= LEVEL_TWO) ? ram_nos : '0;
  assign level = level_q;
  assign empty = is_empty;
  assign full  = is_full;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule

// File: tb/tb_stack_tos.sv
// Self-checking bench for stack_tos: saturate and wrap instances (DEPTH=4)
// driven in lockstep and compared to a queue-based reference model.
module tb_stack_tos;

  localparam int NB = 32;
  localparam int DP = 4;

  logic          clk;
  logic          rst;
  logic          push, pop, flush, clr_err;
  logic [NB-1:0] din;

  logic [NB-1:0] s_tos, s_nos, w_tos, w_nos;
  logic [2:0]    s_level, w_level;
  logic          s_empty, s_full, s_ovf, s_udf;
  logic          w_empty, w_full, w_ovf, w_udf;

  int n_checks = 0;
  int n_fail   = 0;
  int txn      = 0;

  typedef logic [NB-1:0] dq_t[$];
  dq_t mq[2];
  bit  m_ovf[2];
  bit  m_udf[2];

  stack_tos #(.NBDATA(NB), .DEPTH(DP), .OVFMODE(0)) u_sat (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
    .clr_err(clr_err), .din(din), .tos(s_tos), .nos(s_nos),
    .level(s_level), .empty(s_empty), .full(s_full), .ovf(s_ovf), .udf(s_udf)
  );

  stack_tos #(.NBDATA(NB), .DEPTH(DP), .OVFMODE(1)) u_wrap (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
    .clr_err(clr_err), .din(din), .tos(w_tos), .nos(w_nos),
    .level(w_level), .empty(w_empty), .full(w_full), .ovf(w_ovf), .udf(w_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h (txn %0d)", tag, obs, exp, txn);
    end
  endtask

  function automatic logic [NB-1:0] exp_tos(input int m);
    return (mq[m].size() > 0) ? mq[m][mq[m].size()-1] : '0;
  endfunction

  function automatic logic [NB-1:0] exp_nos(input int m);
    return (mq[m].size() > 1) ? mq[m][mq[m].size()-2] : '0;
  endfunction

  // Reference: a plain list of entries, newest last; m=1 selects wrap policy
  task automatic model_step(input int m, input logic p, input logic po,
                            input logic f, input logic c, input logic [NB-1:0] d);
    if (c) begin
      m_ovf[m] = 1'b0;
      m_udf[m] = 1'b0;
    end
    if (f) begin
      mq[m].delete();
    end else if (p && po && mq[m].size() > 0) begin
      mq[m][mq[m].size()-1] = d;
    end else if (p) begin
      if (mq[m].size() < DP) begin
        mq[m].push_back(d);
      end else begin
        m_ovf[m] = 1'b1;
        if (m == 1) begin
          void'(mq[m].pop_front());
          mq[m].push_back(d);
        end
      end
    end else if (po) begin
      if (mq[m].size() > 0) void'(mq[m].pop_back());
      else m_udf[m] = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      m_ovf[m] = 1'b0;
      m_udf[m] = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("sat.tos",   s_tos,             exp_tos(0));
    check("sat.nos",   s_nos,             exp_nos(0));
    check("sat.level", NB'(s_level),      NB'(mq[0].size()));
    check("sat.empty", NB'(s_empty),      NB'(mq[0].size() == 0));
    check("sat.full",  NB'(s_full),       NB'(mq[0].size() == DP));
    check("sat.ovf",   NB'(s_ovf),        NB'(m_ovf[0]));
    check("sat.udf",   NB'(s_udf),        NB'(m_udf[0]));
    check("wrap.tos",  w_tos,             exp_tos(1));
    check("wrap.nos",  w_nos,             exp_nos(1));
    check("wrap.level", NB'(w_level),     NB'(mq[1].size()));
    check("wrap.empty", NB'(w_empty),     NB'(mq[1].size() == 0));
    check("wrap.full", NB'(w_full),       NB'(mq[1].size() == DP));
    check("wrap.ovf",  NB'(w_ovf),        NB'(m_ovf[1]));
    check("wrap.udf",  NB'(w_udf),        NB'(m_udf[1]));
  endtask

  task automatic step(input logic p, input logic po, input logic f,
                      input logic c, input logic [NB-1:0] d);
    push = p; pop = po; flush = f; clr_err = c; din = d;
    @(posedge clk);
    model_step(0, p, po, f, c, d);
    model_step(1, p, po, f, c, d);
    #1;
    compare_all();
    $display("txn %0d: push=%0b pop=%0b flush=%0b clr=%0b din=%h | sat lvl=%0d tos=%h | wrap lvl=%0d tos=%h",
             txn, p, po, f, c, d, s_level, s_tos, w_level, w_tos);
    txn++;
    push = 0; pop = 0; flush = 0; clr_err = 0;
  endtask

  // Raise rst between edges with a push pending; outputs must clear at once
  task automatic mid_reset();
    push = 1'b1; din = 32'hDEAD_BEEF;
    #2 rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    check("rst.async_tos",   s_tos,        '0);
    check("rst.async_level", NB'(w_level), '0);
    check("rst.async_empty", NB'(s_empty), 32'd1);
    $display("txn %0d: async reset mid-cycle | sat lvl=%0d wrap lvl=%0d", txn, s_level, w_level);
    txn++;
    push = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; push = 0; pop = 0; flush = 0; clr_err = 0; din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("reset.empty", NB'(s_empty), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Three pushes
    step(1, 0, 0, 0, 32'h11);
    step(1, 0, 0, 0, 32'h22);
    step(1, 0, 0, 0, 32'h33);
    check("push3.tos",   s_tos,        32'h33);
    check("push3.nos",   s_nos,        32'h22);
    check("push3.level", NB'(s_level), 32'd3);
    check("push3.full",  NB'(s_full),  32'd0);
    step(0, 0, 1, 0, '0);

    // Overfill: saturate keeps 1..4, wrap keeps the newest four
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, NB'(i));
    check("sat.ovf_full", NB'(s_full), 32'd1);
    check("sat.ovf_tos",  s_tos,       32'd4);
    check("sat.ovf_nos",  s_nos,       32'd3);
    check("sat.ovf_flag", NB'(s_ovf),  32'd1);
    step(1, 0, 0, 0, 32'd6);
    check("wrap.ovf_tos", w_tos,        32'd6);
    check("wrap.ovf_nos", w_nos,        32'd5);
    check("wrap.ovf_lvl", NB'(w_level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("sat.pop_tos",  s_tos, NB'(4 - i));
      check("wrap.pop_tos", w_tos, NB'(6 - i));
      step(0, 1, 0, 0, '0);
    end
    check("pops.empty", NB'(w_empty), 32'd1);

    // Underflow stickiness vs clr_err
    step(0, 1, 0, 0, '0);
    check("udf.set", NB'(s_udf), 32'd1);
    step(0, 1, 0, 1, '0);
    check("udf.win_over_clr", NB'(s_udf), 32'd1);
    step(0, 0, 0, 1, '0);
    check("udf.cleared", NB'(w_udf), 32'd0);

    // Replace
    step(1, 0, 0, 0, 32'hB);
    step(1, 0, 0, 0, 32'hA);
    step(1, 1, 0, 0, 32'hC);
    check("repl.tos",   s_tos,        32'hC);
    check("repl.nos",   s_nos,        32'hB);
    check("repl.level", NB'(s_level), 32'd2);
    step(0, 0, 1, 0, '0);
    step(1, 1, 0, 0, 32'h7);
    check("repl_empty.level", NB'(w_level), 32'd1);
    check("repl_empty.tos",   w_tos,        32'h7);
    check("repl_empty.udf",   NB'(w_udf),   32'd0);

    // Flush beats push and leaves errors alone
    step(0, 0, 1, 0, '0);
    step(0, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, NB'(32'h40 + i));
    step(1, 0, 1, 0, 32'h99);
    check("flush.level", NB'(s_level), 32'd0);
    check("flush.tos",   s_tos,        32'd0);
    check("flush.udf",   NB'(s_udf),   32'd1);
    step(1, 0, 0, 0, 32'h55);
    step(1, 0, 0, 0, 32'h66);
    mid_reset();

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      int r;
      logic p, po, f, c;
      r  = int'($urandom_range(0, 99));
      p  = (r < 55);
      po = (r >= 35 && r < 90) || ($urandom_range(0, 9) == 0);
      f  = ($urandom_range(0, 39) == 0);
      c  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 149) == 0) mid_reset();
      else step(p, po, f, c, $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
